fpu_sp_reciprocal_seq: RTL and testbench

FPU_SP_RECIPROCAL_SEQ -- requirements
Module: fpu_sp_reciprocal_seq

---
 rtl/fpu_sp_pkg.sv | 52 +++++
 rtl/fpu_sp_mant_divstep.sv | 20 ++
 rtl/fpu_sp_reciprocal_seq.sv | 137 +++++++++++++
 tb/tb_fpu_sp_reciprocal_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_sp_pkg.sv
// Shared single-precision constants, FSM state encoding and special-operand helper.
// FPU_RECIP_FASTPATH_EN is consumed by fpu_sp_reciprocal_seq.
package fpu_sp_pkg;
  localparam int EXP_BIAS = 127;
  localparam int SIGN_W = 1;
  localparam int EXP_W = 8;
  localparam int MANT_W = 23;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t DIV = 2'd1;
  localparam state_t RND = 2'd2;
  localparam state_t DONE = 2'd3;

  typedef struct packed {
    logic hit;
    logic [31:0] res;
    logic ovf;
    logic unf;
  } spec_t;

  // Operands whose reciprocal needs no division: specials and exact powers of two.
  function automatic spec_t spec_chk(input logic [31:0] b);
    logic s;
    logic [EXP_W-1:0] e;
    logic [MANT_W-1:0] m;
    logic [9:0] x;
    spec_chk = '0;
    s = b[31];
    e = b[30:23];
    m = b[22:0];
    x = 10'(2 * EXP_BIAS) - {2'b00, e};
    if (e == 8'hFF) begin
      spec_chk.hit = 1'b1;
      spec_chk.res = (m != '0) ? QNAN : {s, 31'd0};
    end else if (e == 8'h00) begin
      spec_chk.hit = 1'b1;
      spec_chk.res = POS_INF | {s, 31'd0};
      spec_chk.ovf = 1'b1;
    end else if (m == '0) begin
      spec_chk.hit = 1'b1;
      if (x == '0) begin
        spec_chk.res = {s, 31'd0};
        spec_chk.unf = 1'b1;
      end else begin
        spec_chk.res = {s, x[7:0], 23'd0};
      end
    end
  endfunction
endpackage

// File: rtl/fpu_sp_mant_divstep.sv
// One radix-2 restoring division step on the significand.
// Produces the quotient bit and the shifted partial remainder.
module fpu_sp_mant_divstep
  import fpu_sp_pkg::*;
(
  input  logic [MANT_W+2:0] rem,
  input  logic [MANT_W:0]   div,
  output logic [MANT_W+2:0] nxt,
  output logic              q
);
  logic [MANT_W+2:0] diff;

  // Subtract when the divisor fits, then shift for the next bit.
  always_comb begin
    diff = rem - {2'b00, div};
    q = rem >= {2'b00, div};
    nxt = q ? {diff[MANT_W+1:0], 1'b0}
            : {rem[MANT_W+1:0], 1'b0};
  end
endmodule

// File: rtl/fpu_sp_reciprocal_seq.sv
// Sequential single-precision reciprocal, one quotient bit per cycle.
// Define FPU_RECIP_FASTPATH_EN to bypass division for specials and powers of two.
module fpu_sp_reciprocal_seq
  import fpu_sp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             underflow
);
  state_t state;
  logic [4:0] cnt;
  logic [31:0] b_q;
  logic [MANT_W+2:0] rem;
  logic [MANT_W+2:0] rem_nxt;
  logic [MANT_W:0] div;
  logic [MANT_W+1:0] quo;
  logic qbit;

  logic [MANT_W:0] sig;
  logic up;
  logic [MANT_W+1:0] sum;
  logic carry;
  logic [9:0] ex;
  spec_t sp;
  logic [31:0] rnd_res;
  logic rnd_ovf;
  logic rnd_unf;

  assign in_ready = (state == IDLE);

  fpu_sp_mant_divstep u_step (
    .rem (rem),
    .div (div),
    .nxt (rem_nxt),
    .q   (qbit)
  );

  // Round the 25-bit quotient to nearest-even and apply exponent/special rules.
  always_comb begin
    sig = quo[MANT_W+1:1];
    up = quo[0] & ((|rem) | sig[0]);
    sum = {1'b0, sig} + {{(MANT_W+1){1'b0}}, up};
    carry = sum[MANT_W+1];
    ex = 10'(2 * EXP_BIAS - 1) - {2'b00, b_q[30:23]}
       + {9'd0, carry};
    sp = spec_chk(b_q);
    rnd_ovf = 1'b0;
    rnd_unf = 1'b0;
    if (ex[9] || ex == '0) begin
      rnd_res = {b_q[31], 31'd0};
      rnd_unf = 1'b1;
    end else begin
      rnd_res = {b_q[31], ex[7:0],
                 carry ? 23'd0 : sum[MANT_W-1:0]};
    end
    if (sp.hit) begin
      rnd_res = sp.res;
      rnd_ovf = sp.ovf;
      rnd_unf = sp.unf;
    end
  end

`ifdef FPU_RECIP_FASTPATH_EN
  spec_t sp_in;
  assign sp_in = spec_chk(B);
`endif

  // Control FSM plus iterative datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      b_q <= '0;
      rem <= '0;
      div <= '0;
      quo <= '0;
      out_valid <= 1'b0;
      result <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            b_q <= B;
            rem <= (MANT_W+3)'(1) << (MANT_W + 1);
            div <= {1'b1, B[MANT_W-1:0]};
            quo <= '0;
            cnt <= 5'd24;
`ifdef FPU_RECIP_FASTPATH_EN
            if (sp_in.hit) begin
              state <= DONE;
              out_valid <= 1'b1;
              result <= sp_in.res;
              overflow <= sp_in.ovf;
              underflow <= sp_in.unf;
            end else begin
              state <= DIV;
            end
`else
            state <= DIV;
`endif
          end
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= {quo[MANT_W:0], qbit};
          if (cnt == '0) state <= RND;
          else cnt <= cnt - 5'd1;
        end
        RND: begin
          result <= rnd_res;
          overflow <= rnd_ovf;
          underflow <= rnd_unf;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_sp_reciprocal_seq.sv
// Directed bench for fpu_sp_reciprocal_seq with an exact-arithmetic reference.
// Expected latency follows FPU_RECIP_FASTPATH_EN.
module tb_fpu_sp_reciprocal_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] B = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] result;
  logic overflow;
  logic underflow;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] cur_b = '0;

  fpu_sp_reciprocal_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: exact integer quotient 2^47/1.m, rounded nearest-even.
  function automatic logic [33:0] model(input logic [31:0] b);
    logic s;
    int e;
    int x;
    longint unsigned d;
    longint unsigned q;
    longint unsigned r;
    s = b[31];
    e = int'(b[30:23]);
    if (e == 255)
      return (b[22:0] != 0) ? {32'h7FC0_0000, 2'b00}
                            : {s, 31'd0, 2'b00};
    if (e == 0) return {s, 8'hFF, 23'd0, 2'b10};
    d = (64'd1 << 23) | longint'(b[22:0]);
    q = (64'd1 << 47) / d;
    r = (64'd1 << 47) % d;
    x = 253 - e;
    if (2 * r > d || (2 * r == d && q[0])) q++;
    if (q >= (64'd1 << 24)) begin
      q = q >> 1;
      x++;
    end
    if (x <= 0) return {s, 31'd0, 2'b01};
    return {s, x[7:0], q[22:0], 2'b00};
  endfunction

  // Whenever a result is presented it must match the reference for the operand in flight.
  always @(negedge clk) begin
    logic [33:0] m;
    if (rst_n && out_valid) begin
      m = model(cur_b);
      chk("mon_result", result, m[33:2]);
      chk("mon_flags", {30'd0, overflow, underflow}, {30'd0, m[1:0]});
      chk("mon_in_ready", {31'd0, in_ready}, 32'd0);
    end
  end

  task automatic send(input logic [31:0] b, input logic [31:0] er,
                      input logic eo, input logic eu, input int hold);
    int lat;
    int elat;
    logic fast;
    logic [33:0] m;
    m = model(b);
    chk("model_res", m[33:2], er);
    chk("model_flg", {30'd0, m[1:0]}, {30'd0, eo, eu});
    fast = (b[30:23] == 8'h00) || (b[30:23] == 8'hFF)
        || (b[22:0] == 23'd0);
`ifdef FPU_RECIP_FASTPATH_EN
    elat = fast ? 1 : 27;
`else
    elat = fast ? 27 : 27;
`endif
    @(negedge clk);
    chk("idle_ready", {31'd0, in_ready}, 32'd1);
    cur_b = b;
    B = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    B = 32'hDEAD_BEEF;
    lat = 1;
    while (!out_valid && lat < 80) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, elat);
    chk("result", result, er);
    chk("flags", {30'd0, overflow, underflow}, {30'd0, eo, eu});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      B = 32'h4000_0000;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_valid", {31'd0, out_valid}, 32'd0);
    chk("release_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(32'h4000_0000, 32'h3F00_0000, 1'b0, 1'b0, 0);
    send(32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 1'b0, 10);
    send(32'hC080_0000, 32'hBE80_0000, 1'b0, 1'b0, 0);
    send(32'h0000_0000, 32'h7F80_0000, 1'b1, 1'b0, 0);
    send(32'h7F80_0000, 32'h0000_0000, 1'b0, 1'b0, 0);
    send(32'h7FC0_0001, 32'h7FC0_0000, 1'b0, 1'b0, 0);
    send(32'h7F00_0001, 32'h0000_0000, 1'b0, 1'b1, 0);
    send(32'h0040_0000, 32'h7F80_0000, 1'b1, 1'b0, 0);
    send(32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 0);
    send(32'hBFC0_0000, 32'hBF2A_AAAB, 1'b0, 1'b0, 2);
    send(32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b0, 0);
    send(32'h8000_0000, 32'hFF80_0000, 1'b1, 1'b0, 0);
    send(32'h7F00_0000, 32'h0000_0000, 1'b0, 1'b1, 0);
    send(32'h7E80_0000, 32'h0080_0000, 1'b0, 1'b0, 0);
    send(32'h7E80_0001, 32'h0000_0000, 1'b0, 1'b1, 0);

    // Reset in the middle of the division.
    @(negedge clk);
    cur_b = 32'h4040_0000;
    B = 32'h4040_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_result", result, 32'd0);
    chk("midrst_flags", {30'd0, overflow, underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
